// File: rtl/shift_out_pkg.sv
// rtl/shift_out_pkg.sv - shared state encodings and count-width helper for shift_out
package shift_out_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..width-1; never less than one bit.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - bit counter with clear, increment and terminal-count flag
module shift_bit_counter
    import shift_out_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_terminal
);

    localparam int CW = count_width(WIDTH);

    logic [CW-1:0] r_count;

    // Count shifted bits; clear wins over increment so the count wraps to 0 at word end.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_out.sv
// rtl/shift_out.sv - parallel-in serial-out transmitter, MSB first, enable-strobed
module shift_out
    import shift_out_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    input  logic             enable,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_terminal;

    assign w_accept = (r_state == ST_IDLE) && load;
    assign w_step   = (r_state == ST_SHIFT) && enable;
    assign w_last   = w_step && w_terminal;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_clear    (w_accept || w_last),
        .i_inc      (w_step),
        .o_terminal (w_terminal)
    );

    // Load/shift FSM; enable is ignored while idle so the first bit gets a full enable period.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shreg <= din;
                        r_done  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (enable) begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        if (w_terminal) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The MSB of the zero-filled shift register is the registered serial bit: it holds
    // din's MSB after a load, the next bit after each shift, and 0 after the last shift.
    assign so    = r_shreg[WIDTH-1];
    assign done  = r_done;
    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_SHIFT);

endmodule
